// File: rtl/rom_arb_pkg.sv
// Shared definitions for the instruction-ROM read arbiter: widths, requester
// ids, response-state encoding and the address error check.
package rom_arb_pkg;

    localparam int ADDR_W        = 11;
    localparam int DATA_W        = 32;
    localparam int WORD_IDX_LSB  = 2;
    localparam int MAX_BYTE_ADDR = 1023;
    localparam int STARVE_LIMIT  = 8;

    // Requester identity carried through the pending-response register.
    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } req_id_e;

    // Pending-response register state: is a ROM word due next cycle.
    typedef enum logic {
        IDLE_RSP = 1'b0,
        RSP      = 1'b1
    } rsp_state_e;

    // A request errors when it is not word aligned or lies beyond the ROM.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[WORD_IDX_LSB-1:0] != '0);
        out_of_range = ({{(32-ADDR_W){1'b0}}, addr} > 32'(MAX_BYTE_ADDR));
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// Grant selection for the ROM read arbiter. Produces a one-hot (or zero)
// grant from the two request lines.
// Build option: ROM_ARB_ROUND_ROBIN_EN selects round-robin on contention;
// otherwise m0 has fixed priority and m1 is rescued by a starvation count.
module rom_arb_pick
    import rom_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int STARVE_W     = 4
) (
    input  logic                m0_req,
    input  logic                m1_req,
`ifdef ROM_ARB_ROUND_ROBIN_EN
    input  logic                rr_ptr,
`else
    input  logic [STARVE_W-1:0] starve_cnt,
`endif
    output logic [1:0]          gnt
);

`ifdef ROM_ARB_ROUND_ROBIN_EN
    // On contention the pointer names the requester that should win next.
    always_comb begin
        gnt    = 2'b00;
        gnt[1] = m1_req && (!m0_req || (rr_ptr == M1));
        gnt[0] = m0_req && !gnt[1];
    end
`else
    // m0 wins contention unless m1 has been denied for the full limit.
    always_comb begin
        logic force_m1;
        force_m1 = m1_req && (starve_cnt == STARVE_W'(STARVE_LIMIT));
        gnt      = 2'b00;
        gnt[1]   = m1_req && (!m0_req || force_m1);
        gnt[0]   = m0_req && !gnt[1];
    end
`endif

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares the instruction ROM's single registered read port between the
// fetch unit (m0) and the debug/data port (m1). One grant per cycle, fixed
// one-cycle latency from grant to rvalid, no stall path.
// Build option: ROM_ARB_ROUND_ROBIN_EN (round-robin instead of fixed
// priority with starvation rescue).
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = rom_arb_pkg::STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [1:0]        pick_gnt;
    logic [1:0]        gnt;
    logic              any_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_err;

    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    rsp_state_e        rsp_q;
    req_id_e           pend_id_q;
    logic              pend_err_q;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    req_id_e           rr_q, rr_d;
`else
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
`endif

    rom_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .STARVE_W     (STARVE_W)
    ) u_pick (
        .m0_req     (m0_req),
        .m1_req     (m1_req),
`ifdef ROM_ARB_ROUND_ROBIN_EN
        .rr_ptr     (rr_q),
`else
        .starve_cnt (starve_cnt_q),
`endif
        .gnt        (pick_gnt)
    );

    // No grant may be issued while reset is held.
    always_comb begin
        gnt      = aclr ? 2'b00 : pick_gnt;
        any_gnt  = |gnt;
        sel_addr = gnt[1] ? m1_addr : m0_addr;
        sel_err  = addr_err(sel_addr);
    end

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // ROM address follows the winner; without a grant it holds the last
    // granted address so the ROM output does not move.
    always_comb begin
        rom_addr    = any_gnt ? sel_addr : addr_hold_q;
        addr_hold_d = rom_addr;
    end

`ifdef ROM_ARB_ROUND_ROBIN_EN
    // Pointer moves to the loser only when both requesters competed.
    always_comb begin
        rr_d = rr_q;
        if (m0_req && m1_req && any_gnt) begin
            rr_d = gnt[1] ? M0 : M1;
        end
    end
`else
    // Count consecutive m1 denials; clear on an m1 grant or a quiet m1.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m1_req || gnt[1]) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end
`endif

    // Arbitration state and address hold register.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            addr_hold_q  <= '0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            rr_q         <= M0;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            addr_hold_q  <= addr_hold_d;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            rr_q         <= rr_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    // Pending-response FSM: records who was granted and whether it errored.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            rsp_q      <= IDLE_RSP;
            pend_id_q  <= M0;
            pend_err_q <= 1'b0;
        end else begin
            case (rsp_q)
                IDLE_RSP: if (any_gnt)  rsp_q <= RSP;
                RSP:      if (!any_gnt) rsp_q <= IDLE_RSP;
                default:                rsp_q <= IDLE_RSP;
            endcase
            if (any_gnt) begin
                pend_id_q  <= gnt[1] ? M1 : M0;
                pend_err_q <= sel_err;
            end
        end
    end

    logic [1:0]        rvalid_v;
    logic [1:0]        err_v;
    logic [DATA_W-1:0] rdata_v [2];

    // Steer the ROM word to the requester that owns the pending slot;
    // errored reads return zero data.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        always_comb begin
            rvalid_v[gi] = (rsp_q == RSP) && (pend_id_q == ((gi == 1) ? M1 : M0));
            err_v[gi]    = rvalid_v[gi] && pend_err_q;
            rdata_v[gi]  = (rvalid_v[gi] && !pend_err_q) ? rom_dout : '0;
        end
    end

    assign m0_rvalid = rvalid_v[0];
    assign m0_err    = err_v[0];
    assign m0_rdata  = rdata_v[0];
    assign m1_rvalid = rvalid_v[1];
    assign m1_err    = err_v[1];
    assign m1_rdata  = rdata_v[1];

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: a behavioural ROM, a table of per-cycle
// request vectors with expected grants/address, and a response scoreboard.
module tb_rom_read_arbiter;

    logic        clk = 1'b0;
    logic        aclr;
    logic        m0_req, m1_req;
    logic [10:0] m0_addr, m1_addr;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [10:0] rom_addr;
    logic [31:0] rom_dout;
    logic [10:0] rom_q;

    always #5 clk = ~clk;

    rom_read_arbiter dut (
        .clk       (clk),
        .aclr      (aclr),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout)
    );

    function automatic logic [31:0] rom_word(input logic [8:0] idx);
        return 32'hC0DE_0000 ^ ({23'd0, idx} * 32'h0000_0101);
    endfunction

    // ROM model: address registered on the clock, cleared by reset.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) rom_q <= '0;
        else      rom_q <= rom_addr;
    end
    assign rom_dout = rom_word(rom_q[10:2]);

    typedef struct {
        logic        m0_req;
        logic [10:0] m0_addr;
        logic        m1_req;
        logic [10:0] m1_addr;
        logic        g0;
        logic        g1;
        logic [10:0] rom;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    vec_t        vecs [64];
    int          nvec;
    logic [10:0] last_addr;
    rsp_t        sb [$];
    int          total;
    int          bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r0, input logic [10:0] a0, input logic r1,
                                input logic [10:0] a1, input logic g0, input logic g1,
                                input logic [10:0] rom);
        vec_t v;
        v.m0_req = r0; v.m0_addr = a0; v.m1_req = r1; v.m1_addr = a1;
        v.g0 = g0; v.g1 = g1; v.rom = rom;
        return v;
    endfunction

    task automatic addv(input logic r0, input logic [10:0] a0, input logic r1,
                        input logic [10:0] a1, input logic g0, input logic g1);
        logic [10:0] rom;
        rom = g0 ? a0 : (g1 ? a1 : last_addr);
        last_addr = rom;
        vecs[nvec] = mk(r0, a0, r1, a1, g0, g1, rom);
        nvec++;
    endtask

    function automatic rsp_t exp_rsp(input logic id, input logic [10:0] a);
        rsp_t r;
        r.id   = id;
        r.err  = (a[1:0] != 2'b00) || (a > 11'd1023);
        r.data = r.err ? 32'd0 : rom_word(a[10:2]);
        return r;
    endfunction

    // Drive one cycle of requests, check the previous cycle's response and
    // this cycle's grant/address, then queue any expected response.
    task automatic apply(input vec_t v, input int n);
        rsp_t e;
        m0_req = v.m0_req; m0_addr = v.m0_addr;
        m1_req = v.m1_req; m1_addr = v.m1_addr;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("m0_rvalid", 32'(m0_rvalid), 32'(e.id == 1'b0));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(e.id == 1'b1));
            chk("m0_rdata", m0_rdata, (e.id == 1'b0) ? e.data : 32'd0);
            chk("m1_rdata", m1_rdata, (e.id == 1'b1) ? e.data : 32'd0);
            chk("m0_err", 32'(m0_err), 32'((e.id == 1'b0) && e.err));
            chk("m1_err", 32'(m1_err), 32'((e.id == 1'b1) && e.err));
        end else begin
            chk("m0_rvalid_idle", 32'(m0_rvalid), 32'd0);
            chk("m1_rvalid_idle", 32'(m1_rvalid), 32'd0);
        end
        chk("m0_gnt", 32'(m0_gnt), 32'(v.g0));
        chk("m1_gnt", 32'(m1_gnt), 32'(v.g1));
        chk("rom_addr", 32'(rom_addr), 32'(v.rom));
        if (v.g0) sb.push_back(exp_rsp(1'b0, v.m0_addr));
        if (v.g1) sb.push_back(exp_rsp(1'b1, v.m1_addr));
        $display("vec %0d: m0 req=%b addr=%h  m1 req=%b addr=%h  gnt=%b%b rom_addr=%h",
                 n, v.m0_req, v.m0_addr, v.m1_req, v.m1_addr, m1_gnt, m0_gnt, rom_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g1;
        total = 0; bad = 0; nvec = 0; last_addr = 11'h000;

        // Single read, hold, m1 errors, m1 good read.
        addv(1, 11'h004, 0, 11'h000, 1, 0);
        addv(0, 11'h000, 0, 11'h000, 0, 0);
        addv(0, 11'h000, 1, 11'h006, 0, 1);
        addv(0, 11'h000, 1, 11'h400, 0, 1);
        addv(0, 11'h000, 1, 11'h008, 0, 1);
        // Streaming 8 words back to back on m0.
        for (int i = 0; i < 8; i++) addv(1, 11'(4 * i), 0, 11'h000, 1, 0);
        // m0 misaligned error, then idle.
        addv(1, 11'h005, 0, 11'h000, 1, 0);
        addv(0, 11'h000, 0, 11'h000, 0, 0);
        // Short contention, then m1 drops its request for a cycle.
        for (int i = 0; i < 5; i++) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
            g1 = (i % 2 == 1);
`else
            g1 = 1'b0;
`endif
            addv(1, 11'(11'h020 + 4 * i), 1, 11'(11'h100 + 4 * i), !g1, g1);
        end
        addv(1, 11'h03C, 0, 11'h000, 1, 0);
        // Sustained contention.
        for (int i = 0; i < 10; i++) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
            g1 = (i % 2 == 0);
`else
            g1 = (i == 8);
`endif
            addv(1, 11'(11'h040 + 4 * i), 1, 11'(11'h200 + 4 * i), !g1, g1);
        end
        addv(0, 11'h000, 0, 11'h000, 0, 0);

        aclr = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m1_req = 1'b0; m1_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_m0_err", 32'(m0_err), 32'd0);
        chk("rst_m1_err", 32'(m1_err), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        @(posedge clk);
        #1;
        aclr = 1'b0;

        for (int i = 0; i < nvec; i++) apply(vecs[i], i);

        // Reset while a response is pending: it must be dropped.
        apply(mk(1, 11'h010, 0, 11'h000, 1, 0, 11'h010), 100);
        aclr = 1'b1;
        m0_req = 1'b1; m0_addr = 11'h010; m1_req = 1'b1; m1_addr = 11'h014;
        #1;
        chk("mid_rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("mid_rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("mid_rst_m0_rdata", m0_rdata, 32'd0);
        chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("mid_rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("mid_rst_m1_gnt", 32'(m1_gnt), 32'd0);
        sb.delete();
        $display("reset asserted mid-operation, pending response discarded");
        @(posedge clk);
        #1;
        aclr = 1'b0;
        apply(mk(1, 11'h010, 0, 11'h000, 1, 0, 11'h010), 101);
        apply(mk(0, 11'h000, 0, 11'h000, 0, 0, 11'h010), 102);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
